// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiplier operand path.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: fetch FSM state, fetch kind, and the reference operand address
// function (base + row*K + k for rows, base + k*COLS + col for columns).
package matmul_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    typedef enum logic {
        ROW = 1'b0,
        COL = 1'b1
    } fetch_kind_t;

    // Full 32-bit result; callers truncate to their address width, which
    // gives the required modulo-2^ADDR_WIDTH wrap.
    function automatic logic [31:0] calc_fetch_addr(
        input fetch_kind_t kind,
        input logic [31:0] base,
        input logic [31:0] idx,
        input logic [31:0] k,
        input logic [31:0] k_dim,
        input logic [31:0] cols
    );
        if (kind == ROW) begin
            return base + idx * k_dim + k;
        end
        return base + k * cols + idx;
    endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Running operand address generator: element counter k plus current address.
// Latency: loaded/advanced values visible the cycle after load_i / adv_i.
// Backpressure: only advances on adv_i (an accepted request), so addr_o holds while ungranted.
// Ports: load_i/kind_i/start_addr_i start a new vector; adv_i steps k and
// the address by 1 (row) or COLS (column); addr_o/k_o are the registered values.
module fetch_addr_gen
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int K          = 8,
    parameter int COLS       = 10,
    parameter int KW         = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  fetch_kind_t           kind_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic                  adv_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [KW-1:0]         k_o
);

    localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(COLS);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [KW-1:0]         k_q, k_d;
    fetch_kind_t           kind_q, kind_d;

    // Incremental stepping keeps a multiplier out of the issue path; only
    // the start address is computed from the index.
    always_comb begin
        addr_d = addr_q;
        k_d    = k_q;
        kind_d = kind_q;
        if (load_i) begin
            addr_d = start_addr_i;
            k_d    = '0;
            kind_d = kind_i;
        end else if (adv_i) begin
            addr_d = addr_q + ((kind_q == ROW) ? ADDR_WIDTH'(1) : COL_STEP);
            k_d    = k_q + KW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            k_q    <= '0;
            kind_q <= ROW;
        end else begin
            addr_q <= addr_d;
            k_q    <= k_d;
            kind_q <= kind_d;
        end
    end

    assign addr_o = addr_q;
    assign k_o    = k_q;

endmodule

// File: rtl/operand_fetch_server.sv
// Operand fetch server: turns row/column fetch pulses into K in-order memory reads and a parallel buffer.
// Latency: pulse at t -> mem_req t+1..t+K -> buf_valid from t+K+2 (gnt=1, 1-cycle read).
// Backpressure: mem_req stalls on ~mem_gnt or MAX_OUTSTANDING in flight; fetch_stall rejects new pulses.
// Ports: fetch_row/fetch_col + row_idx/col_idx request; a_base/b_base matrix
// bases; mem_* req/gnt/rvalid read port; buf_data/buf_valid result; fetch_stall,
// data_stall status; err one-cycle pulse for rejected pulses and stray rvalid.
module operand_fetch_server
    import matmul_pkg::*;
#(
    parameter int ROWS            = 8,
    parameter int K               = 8,
    parameter int COLS            = 10,
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fetch_row,
    input  logic                           fetch_col,
    input  logic [$clog2(ROWS)-1:0]        row_idx,
    input  logic [$clog2(COLS)-1:0]        col_idx,
    input  logic [ADDR_WIDTH-1:0]          a_base,
    input  logic [ADDR_WIDTH-1:0]          b_base,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [0:K-1][DATA_WIDTH-1:0]   buf_data,
    output logic                           buf_valid,
    output logic                           fetch_stall,
    output logic                           data_stall,
    output logic                           err
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int KW = $clog2(K + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    // One extra bit so the range check is meaningful even when ROWS/COLS
    // is a power of two.
    localparam logic [RW:0]   ROWS_L = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COLS_L = (CW + 1)'(COLS);
    localparam logic [KW-1:0] K_L    = KW'(K);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [OW-1:0] MAX_L  = OW'(MAX_OUTSTANDING);

    fetch_state_t                 state_q, state_d;
    logic                         pend_q, pend_d;
    logic [CW-1:0]                pend_idx_q, pend_idx_d;
    logic [KW-1:0]                rcv_q, rcv_d;
    logic [OW-1:0]                outst_q, outst_d;
    logic [0:K-1][DATA_WIDTH-1:0] buf_q, buf_d;
    logic                         bv_q, bv_d;
    logic                         err_q, err_d;

    logic [KW-1:0]         issued;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  idle, row_ok, col_ok;
    logic                  acc_row, acc_col, set_pend, start_pend, load;
    logic                  gnt_fire, rsp_ok, last_rsp;
    fetch_kind_t           load_kind;
    logic [ADDR_WIDTH-1:0] load_addr;

    assign idle   = (state_q == IDLE);
    assign row_ok = ({1'b0, row_idx} < ROWS_L);
    assign col_ok = ({1'b0, col_idx} < COLS_L);

    // Row wins a same-cycle collision; the column is parked as pending.
    assign acc_row  = idle & fetch_row & row_ok;
    assign acc_col  = idle & fetch_col & col_ok & ~acc_row;
    assign set_pend = acc_row & fetch_col & col_ok;

    assign fetch_stall = (state_q == FETCH) | pend_q;
    assign mem_req     = (state_q == FETCH) && (issued < K_L) && (outst_q < MAX_L);
    assign gnt_fire    = mem_req & mem_gnt;
    assign rsp_ok      = mem_rvalid & (outst_q != '0);
    assign last_rsp    = rsp_ok & (rcv_q == K_LAST);
    // Pending column starts on the same edge the row completes, so there is
    // no IDLE cycle between the two fetches.
    assign start_pend  = last_rsp & pend_q;
    assign load        = acc_row | acc_col | start_pend;

    always_comb begin
        load_kind = COL;
        load_addr = ADDR_WIDTH'(calc_fetch_addr(COL, 32'(b_base), 32'(pend_idx_q),
                                                32'd0, K, COLS));
        if (acc_row) begin
            load_kind = ROW;
            load_addr = ADDR_WIDTH'(calc_fetch_addr(ROW, 32'(a_base), 32'(row_idx),
                                                    32'd0, K, COLS));
        end else if (acc_col) begin
            load_kind = COL;
            load_addr = ADDR_WIDTH'(calc_fetch_addr(COL, 32'(b_base), 32'(col_idx),
                                                    32'd0, K, COLS));
        end
    end

    fetch_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .K          (K),
        .COLS       (COLS),
        .KW         (KW)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .kind_i       (load_kind),
        .start_addr_i (load_addr),
        .adv_i        (gnt_fire),
        .addr_o       (gen_addr),
        .k_o          (issued)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        rcv_d      = rcv_q;
        buf_d      = buf_q;
        bv_d       = bv_q;
        outst_d    = outst_q + OW'(gnt_fire) - OW'(rsp_ok);
        err_d      = ((fetch_row | fetch_col) & fetch_stall)
                   | (idle & fetch_row & ~row_ok)
                   | (idle & fetch_col & ~col_ok)
                   | (mem_rvalid & (outst_q == '0));

        case (state_q)
            IDLE:    if (acc_row | acc_col) state_d = FETCH;
            FETCH:   if (last_rsp) state_d = pend_q ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase

        if (set_pend) begin
            pend_d     = 1'b1;
            pend_idx_d = col_idx;
        end else if (start_pend) begin
            pend_d = 1'b0;
        end

        for (int j = 0; j < K; j++) begin
            if (rsp_ok && (rcv_q == KW'(j))) buf_d[j] = mem_rdata;
        end

        if (load)        rcv_d = '0;
        else if (rsp_ok) rcv_d = rcv_q + KW'(1);

        // Set on completion; any FETCH cycle without completion clears it,
        // which yields the single-cycle pulse between row and pending column.
        if (last_rsp)                       bv_d = 1'b1;
        else if (load || state_q == FETCH)  bv_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            rcv_q      <= '0;
            outst_q    <= '0;
            buf_q      <= '0;
            bv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            rcv_q      <= rcv_d;
            outst_q    <= outst_d;
            buf_q      <= buf_d;
            bv_q       <= bv_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr   = gen_addr;
    assign buf_data   = buf_q;
    assign buf_valid  = bv_q;
    assign err        = err_q;
    assign data_stall = (state_q == FETCH) & ~bv_q;

endmodule
